// File: rtl/rgb_byte_unpacker.sv
// ============================================================================
// rgb_byte_unpacker - assembles R,G,B byte triplets into top-down addressed pixels (rev 1.0)
// ============================================================================
`default_nettype none

module rgb_byte_unpacker #(
  parameter int HEIGHT = 512,
  parameter int WIDTH  = 768,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_r,
  output logic [7:0]        m_g,
  output logic [7:0]        m_b,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_W-1:0] c_addr_init = ADDR_W'(WIDTH*(HEIGHT-1));
  localparam logic [ADDR_W-1:0] c_row_back  = ADDR_W'(2*WIDTH-1);
  localparam logic [ADDR_W-1:0] c_last_pix  = ADDR_W'(WIDTH*HEIGHT-1);
  localparam logic [COL_W-1:0]  c_last_col  = COL_W'(WIDTH-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [7:0]        r_q, r_d, g_q, g_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] addr_next_q, addr_next_d;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_r_q, m_r_d, m_g_q, m_g_d, m_b_q, m_b_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;
  logic              s_xfer;

  // The B byte may only be taken when the output register is free or draining this cycle
  assign s_ready = (state_q == ST_RUN) && ((phase_q != 2'd2) || !m_valid_q || m_ready);
  assign s_xfer  = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    r_d         = r_q;
    g_d         = g_q;
    col_d       = col_q;
    pix_cnt_d   = pix_cnt_q;
    addr_next_d = addr_next_q;
    m_valid_d   = m_valid_q && !m_ready;
    m_r_d       = m_r_q;
    m_g_d       = m_g_q;
    m_b_d       = m_b_q;
    m_addr_d    = m_addr_q;
    m_last_d    = m_last_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          addr_next_d = c_addr_init;
          col_d       = '0;
          pix_cnt_d   = '0;
          phase_d     = 2'd0;
        end
      end
      ST_RUN: begin
        if (s_xfer) begin
          case (phase_q)
            2'd0: begin
              r_d     = s_data;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = s_data;
              phase_d = 2'd2;
            end
            default: begin
              phase_d   = 2'd0;
              m_valid_d = 1'b1;
              m_r_d     = r_q;
              m_g_d     = g_q;
              m_b_d     = s_data;
              m_addr_d  = addr_next_q;
              m_last_d  = (pix_cnt_q == c_last_pix);
              pix_cnt_d = pix_cnt_q + ADDR_W'(1);
              // File rows run bottom-up: end of a row jumps to the start of the row above
              if (col_q == c_last_col) begin
                addr_next_d = addr_next_q - c_row_back;
                col_d       = '0;
              end else begin
                addr_next_d = addr_next_q + ADDR_W'(1);
                col_d       = col_q + COL_W'(1);
              end
              if (pix_cnt_q == c_last_pix) begin
                state_d = ST_DRAIN;
              end
            end
          endcase
        end
      end
      ST_DRAIN: begin
        if (m_valid_q && m_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      r_q         <= '0;
      g_q         <= '0;
      col_q       <= '0;
      pix_cnt_q   <= '0;
      addr_next_q <= '0;
      m_valid_q   <= 1'b0;
      m_r_q       <= '0;
      m_g_q       <= '0;
      m_b_q       <= '0;
      m_addr_q    <= '0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      r_q         <= r_d;
      g_q         <= g_d;
      col_q       <= col_d;
      pix_cnt_q   <= pix_cnt_d;
      addr_next_q <= addr_next_d;
      m_valid_q   <= m_valid_d;
      m_r_q       <= m_r_d;
      m_g_q       <= m_g_d;
      m_b_q       <= m_b_d;
      m_addr_q    <= m_addr_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_r     = m_r_q;
  assign m_g     = m_g_q;
  assign m_b     = m_b_q;
  assign m_addr  = m_addr_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

`default_nettype wire
